// File: rtl/stage_writeback.sv
// Writeback stage: retires execute-stage results to DRAM, the EXT output port and the loop branch unit.
// Optional forwarding bus enabled by the STAGE_WRITEBACK_FWD_EN macro; constant zero otherwise.
module stage_writeback #(
  parameter  int A_WIDTH    = 12,
  parameter  int D_WIDTH    = 8,
  localparam int OPCODE_MSB = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_MSB:0]   operation_in,
  input  logic [D_WIDTH-1:0]    a,
  input  logic [A_WIDTH-1:0]    dp_cache,
  output logic                  ack,
  output logic                  dwe,
  output logic [A_WIDTH-1:0]    dwa,
  output logic [D_WIDTH-1:0]    dwd,
  output logic [7:0]            xd,
  output logic                  xrda,
  input  logic                  xack,
  output logic                  branch_valid,
  output logic                  branch_taken,
  output logic [15:0]           out_count,
  output logic                  fwd_valid,
  output logic [A_WIDTH-1:0]    fwd_addr,
  output logic [D_WIDTH-1:0]    fwd_data,
  output logic                  dbg_state,
  output logic [OPCODE_MSB:0]   dbg_last_op
);

  // One-hot opcode bit positions shared with the execute stage.
  localparam int OP_INC       = 0;
  localparam int OP_DEC       = 1;
  localparam int OP_INCDP     = 2;
  localparam int OP_DECDP     = 3;
  localparam int OP_IN        = 4;
  localparam int OP_OUT       = 5;
  localparam int OP_LOOPBEGIN = 6;
  localparam int OP_LOOPEND   = 7;

  typedef enum logic {
    IDLE     = 1'b0,
    OUT_WAIT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic write_acc;
  logic out_acc;
  logic loop_acc;
  logic taken_next;
  logic out_done;
  logic op_present;

  // Handshakes: execute -> writeback transfers when operation_in != 0 and ack = 1 at a rising edge;
  // writeback -> EXT transfers when xrda = 1 and xack = 1 at a rising edge (xack is ignored otherwise).
  assign ack       = (state == IDLE);
  assign xrda      = (state == OUT_WAIT);
  assign dbg_state = (state == OUT_WAIT);

  always_comb begin
    state_next = state;
    write_acc  = 1'b0;
    out_acc    = 1'b0;
    loop_acc   = 1'b0;
    taken_next = 1'b0;
    out_done   = 1'b0;
    op_present = 1'b0;
    case (state)
      IDLE: begin
        op_present = |operation_in;
        write_acc  = operation_in[OP_INC] | operation_in[OP_DEC] | operation_in[OP_IN];
        out_acc    = operation_in[OP_OUT];
        loop_acc   = operation_in[OP_LOOPBEGIN] | operation_in[OP_LOOPEND];
        // Both loop bits together resolve as the OR of their individual decisions.
        taken_next = (operation_in[OP_LOOPBEGIN] && (a == '0)) ||
                     (operation_in[OP_LOOPEND]   && (a != '0));
        if (out_acc) begin
          state_next = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (xack) begin
          out_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwe          <= 1'b0;
      dwa          <= '0;
      dwd          <= '0;
      xd           <= '0;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
      out_count    <= '0;
      dbg_last_op  <= '0;
    end else begin
      dwe          <= write_acc;
      branch_valid <= loop_acc;
      branch_taken <= taken_next;
      if (write_acc) begin
        dwa <= dp_cache;
        dwd <= a;
      end
      // xd is loaded only on accept, so it stays stable for the whole OUT_WAIT period.
      if (out_acc) begin
        xd <= a[7:0];
      end
      if (out_done) begin
        out_count <= out_count + 16'd1;
      end
      if (op_present) begin
        dbg_last_op <= operation_in;
      end
    end
  end

`ifdef STAGE_WRITEBACK_FWD_EN
  assign fwd_valid = dwe;
  assign fwd_addr  = dwa;
  assign fwd_data  = dwd;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_stage_writeback.sv
// Scoreboard bench for stage_writeback: directed vectors push expectations, a negedge monitor pops and compares.
module tb_stage_writeback;
  localparam int A_WIDTH = 12;
  localparam int D_WIDTH = 8;

  localparam int OP_INC = 0, OP_DEC = 1, OP_INCDP = 2, OP_DECDP = 3;
  localparam int OP_IN = 4, OP_OUT = 5, OP_LB = 6, OP_LE = 7;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]         operation_in = '0;
  logic [D_WIDTH-1:0] a = '0;
  logic [A_WIDTH-1:0] dp_cache = '0;
  logic               xack = 1'b0;
  logic               ack, dwe, xrda, branch_valid, branch_taken, fwd_valid, dbg_state;
  logic [A_WIDTH-1:0] dwa, fwd_addr;
  logic [D_WIDTH-1:0] dwd, fwd_data;
  logic [7:0]         xd, dbg_last_op;
  logic [15:0]        out_count;

  stage_writeback #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
    .clk(clk), .reset(reset), .operation_in(operation_in), .a(a), .dp_cache(dp_cache),
    .ack(ack), .dwe(dwe), .dwa(dwa), .dwd(dwd), .xd(xd), .xrda(xrda), .xack(xack),
    .branch_valid(branch_valid), .branch_taken(branch_taken), .out_count(out_count),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .dbg_state(dbg_state), .dbg_last_op(dbg_last_op)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [A_WIDTH+D_WIDTH-1:0] exp_dram[$];
  logic [7:0]                 exp_ext[$];
  logic                       exp_br[$];
  logic [15:0]                exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] opb(input int b);
    logic [7:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // monitor
  logic [A_WIDTH+D_WIDTH-1:0] m_dram;
  logic [7:0]                 m_ext;
  logic                       m_br;
  always @(negedge clk) begin
    if (reset) begin
      if (dwe) begin
        if (exp_dram.size() == 0) chk("dram_unexpected", 32'(dwe), 32'(0));
        else begin
          m_dram = exp_dram.pop_front();
          chk("dwa", 32'(dwa), 32'(m_dram[A_WIDTH+D_WIDTH-1:D_WIDTH]));
          chk("dwd", 32'(dwd), 32'(m_dram[D_WIDTH-1:0]));
        end
      end
`ifdef STAGE_WRITEBACK_FWD_EN
      chk("fwd_mirror", {11'(fwd_valid), 12'(fwd_addr), 8'(fwd_data)}, {11'(dwe), 12'(dwa), 8'(dwd)});
`else
      chk("fwd_zero", {11'(fwd_valid), 12'(fwd_addr), 8'(fwd_data)}, 32'(0));
`endif
      if (branch_valid) begin
        if (exp_br.size() == 0) chk("branch_unexpected", 32'(branch_valid), 32'(0));
        else begin
          m_br = exp_br.pop_front();
          chk("branch_taken", 32'(branch_taken), 32'(m_br));
        end
      end else begin
        chk("branch_taken_idle", 32'(branch_taken), 32'(0));
      end
      if (xrda && xack) begin
        if (exp_ext.size() == 0) chk("ext_unexpected", 32'(xrda), 32'(0));
        else begin
          m_ext = exp_ext.pop_front();
          chk("xd", 32'(xd), 32'(m_ext));
        end
      end
    end
  end

  // driver tasks (called at posedge + #1)
  task automatic issue(input logic [7:0] op, input logic [7:0] av, input logic [11:0] dp);
    int n;
    n = 0;
    while (!ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_wait", 32'(ack), 32'(1));
    operation_in = op;
    a = av;
    dp_cache = dp;
    if (op[OP_INC] || op[OP_DEC] || op[OP_IN]) exp_dram.push_back({dp, av});
    if (op[OP_OUT]) exp_ext.push_back(av);
    if (op[OP_LB] || op[OP_LE]) exp_br.push_back((op[OP_LB] && av == 8'h00) || (op[OP_LE] && av != 8'h00));
    @(posedge clk); #1;
    operation_in = '0;
  endtask

  // Finish an OUT transfer: hold xack low for `hold` cycles while presenting `stall` (must not be accepted).
  task automatic finish_out(input logic [7:0] av, input int hold, input logic [7:0] stall);
    for (int i = 0; i < hold; i++) begin
      chk("out_wait_xrda", 32'(xrda), 32'(1));
      chk("out_wait_xd", 32'(xd), 32'(av));
      chk("out_wait_ack", 32'(ack), 32'(0));
      operation_in = stall;
      @(posedge clk); #1;
    end
    xack = 1'b1;
    @(posedge clk); #1;
    xack = 1'b0;
    operation_in = '0;
    exp_cnt = exp_cnt + 16'd1;
    chk("out_done_xrda", 32'(xrda), 32'(0));
    chk("out_done_ack", 32'(ack), 32'(1));
    chk("out_count", 32'(out_count), 32'(exp_cnt));
  endtask

  logic [7:0] out_tab [6] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'(1));
    chk("rst_strobes", {29'(dwe), 1'(xrda), 1'(branch_valid), 1'(branch_taken)}, 32'(0));
    chk("rst_dram", {12'(dwa), 8'(dwd)}, 32'(0));
    chk("rst_xd", 32'(xd), 32'(0));
    chk("rst_count", 32'(out_count), 32'(0));
    chk("rst_fwd", {11'(fwd_valid), 12'(fwd_addr), 8'(fwd_data)}, 32'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // DRAM write, one-cycle strobe
    issue(opb(OP_INC), 8'h05, 12'h123);
    chk("inc_dwe", 32'(dwe), 32'(1));
    chk("inc_dwa", 32'(dwa), 32'h123);
    chk("inc_dwd", 32'(dwd), 32'h05);
    @(posedge clk); #1;
    chk("inc_dwe_drop", 32'(dwe), 32'(0));
    issue(opb(OP_DEC), 8'hFE, 12'hFFF);
    issue(opb(OP_IN), 8'h7F, 12'h010);
`ifdef STAGE_WRITEBACK_FWD_EN
    chk("in_fwd", {11'(fwd_valid), 12'(fwd_addr), 8'(fwd_data)}, {11'(1), 12'h010, 8'h7F});
`else
    chk("in_fwd", {11'(fwd_valid), 12'(fwd_addr), 8'(fwd_data)}, 32'(0));
`endif
    // back-to-back writes
    issue(opb(OP_INC), 8'h11, 12'h001);
    issue(opb(OP_DEC), 8'h22, 12'h002);

    // bubbles and pointer-only ops must produce nothing
    issue(8'h00, 8'h33, 12'h003);
    issue(opb(OP_INCDP), 8'h44, 12'h004);
    issue(opb(OP_DECDP) | opb(OP_INCDP), 8'h55, 12'h005);
    chk("dp_only_dwe", 32'(dwe), 32'(0));

    // xack ignored while idle
    xack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    xack = 1'b0;
    chk("xack_idle_count", 32'(out_count), 32'(exp_cnt));
    chk("xack_idle_xrda", 32'(xrda), 32'(0));

    // OUT with three stalled cycles and a competing op that must not be accepted
    issue(opb(OP_OUT), 8'h41, 12'h000);
    finish_out(8'h41, 3, opb(OP_INC));
    for (int i = 0; i < 6; i++) begin
      issue(opb(OP_OUT), out_tab[i], 12'(i));
      finish_out(out_tab[i], i % 3, 8'h00);
    end

    // loop resolution
    issue(opb(OP_LB), 8'h00, 12'h000);
    chk("lb0_valid", 32'(branch_valid), 32'(1));
    chk("lb0_taken", 32'(branch_taken), 32'(1));
    issue(opb(OP_LE), 8'h00, 12'h000);
    chk("le0_valid", 32'(branch_valid), 32'(1));
    chk("le0_taken", 32'(branch_taken), 32'(0));
    issue(opb(OP_LB), 8'h03, 12'h000);
    issue(opb(OP_LE), 8'h03, 12'h000);
    @(posedge clk); #1;
    chk("branch_valid_drop", 32'(branch_valid), 32'(0));

    // several bits in one accept
    issue(opb(OP_INC) | opb(OP_OUT) | opb(OP_LE), 8'h2A, 12'h0AB);
    chk("multi_dwe", 32'(dwe), 32'(1));
    chk("multi_bv", 32'(branch_valid), 32'(1));
    finish_out(8'h2A, 1, 8'h00);

    // out_count wrap from a preloaded value
    force dut.out_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.out_count;
    exp_cnt = 16'hFFFE;
    @(posedge clk); #1;
    chk("preload_count", 32'(out_count), 32'(exp_cnt));
    issue(opb(OP_OUT), 8'hC3, 12'h000);
    finish_out(8'hC3, 0, 8'h00);
    issue(opb(OP_OUT), 8'h3C, 12'h000);
    finish_out(8'h3C, 1, 8'h00);
    chk("wrap_zero", 32'(out_count), 32'(0));

    // reset during OUT_WAIT abandons the byte
    issue(opb(OP_OUT), 8'h99, 12'h000);
    chk("pre_rst_xrda", 32'(xrda), 32'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_xrda", 32'(xrda), 32'(0));
    chk("mid_rst_count", 32'(out_count), 32'(exp_cnt));
    chk("mid_rst_xd", 32'(xd), 32'(0));
    exp_ext.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack", 32'(ack), 32'(1));
    chk("post_rst_count", 32'(out_count), 32'(exp_cnt));
    issue(opb(OP_OUT), 8'h77, 12'h000);
    finish_out(8'h77, 1, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("dram_queue_empty", 32'(exp_dram.size()), 32'(0));
    chk("ext_queue_empty", 32'(exp_ext.size()), 32'(0));
    chk("branch_queue_empty", 32'(exp_br.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
